// File: rtl/wb_arbiter.sv
// Round-robin arbiter granting up to NR_WB functional-unit results per cycle onto registered writeback ports.
// Optional macro WB_ARB_EX_PRIO_EN: results carrying an exception are granted ahead of normal ones.
module wb_arbiter #(
    parameter int NR_FU   = 4,
    parameter int NR_WB   = 2,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 3,
    parameter int RD_W    = 5,
    parameter int CAUSE_W = 4,
    parameter int RES_W   = IDX_W + RD_W + DATA_W + CAUSE_W + 1,
    parameter int PTR_W   = (NR_FU > 1) ? $clog2(NR_FU) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [NR_FU-1:0]       fu_valid_i,
    input  logic [NR_FU*RES_W-1:0] fu_result_i,
    output logic [NR_FU-1:0]       fu_ready_o,
    output logic [NR_WB-1:0]       wb_valid_o,
    output logic [NR_WB*RES_W-1:0] wb_result_o,
    output logic [PTR_W-1:0]       rr_ptr_o
);

    // Result layout, MSB first: {index, rd, result, ex.cause, ex.valid}
    logic [RES_W-1:0] fu_res_p0 [NR_FU];
    logic [NR_FU-1:0] grant_p0;
    logic [PTR_W-1:0] sel_p0 [NR_WB];
    logic [NR_WB-1:0] port_vld_p0;
    logic [PTR_W-1:0] ptr_nxt_p0;
    logic             any_grant_p0;

    logic [NR_WB-1:0] vld_p1;
    logic [RES_W-1:0] res_p1 [NR_WB];
    logic [PTR_W-1:0] rr_ptr_p1;

    for (genvar i = 0; i < NR_FU; i++) begin : g_unpack
        assign fu_res_p0[i] = fu_result_i[i*RES_W +: RES_W];
    end

`ifdef WB_ARB_EX_PRIO_EN
    logic [NR_FU-1:0] ex_vld_p0;
    for (genvar i = 0; i < NR_FU; i++) begin : g_ex
        assign ex_vld_p0[i] = fu_res_p0[i][0];
    end
`endif

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NR_FU) sum = sum - NR_FU;
        return PTR_W'(sum);
    endfunction

    // ---- stage p0: combinational grant scan starting at the round-robin pointer
    always_comb begin
        int               cnt;
        int               last_off;
        logic [PTR_W-1:0] idx;
        grant_p0     = '0;
        port_vld_p0  = '0;
        any_grant_p0 = 1'b0;
        ptr_nxt_p0   = rr_ptr_p1;
        for (int j = 0; j < NR_WB; j++) sel_p0[j] = '0;
        cnt      = 0;
        last_off = 0;
        idx      = '0;
        if (!rst_i && !flush_i) begin
`ifdef WB_ARB_EX_PRIO_EN
            for (int off = 0; off < NR_FU; off++) begin
                idx = rr_idx(rr_ptr_p1, off);
                if (fu_valid_i[idx] && ex_vld_p0[idx] && cnt < NR_WB) begin
                    grant_p0[idx] = 1'b1;
                    for (int j = 0; j < NR_WB; j++) begin
                        if (j == cnt) begin
                            sel_p0[j]      = idx;
                            port_vld_p0[j] = 1'b1;
                        end
                    end
                    cnt = cnt + 1;
                    if (off > last_off) last_off = off;
                end
            end
`endif
            for (int off = 0; off < NR_FU; off++) begin
                idx = rr_idx(rr_ptr_p1, off);
                if (fu_valid_i[idx] && !grant_p0[idx] && cnt < NR_WB) begin
                    grant_p0[idx] = 1'b1;
                    for (int j = 0; j < NR_WB; j++) begin
                        if (j == cnt) begin
                            sel_p0[j]      = idx;
                            port_vld_p0[j] = 1'b1;
                        end
                    end
                    cnt = cnt + 1;
                    if (off > last_off) last_off = off;
                end
            end
            if (cnt > 0) begin
                any_grant_p0 = 1'b1;
                ptr_nxt_p0   = rr_idx(rr_ptr_p1, last_off + 1);
            end
        end
    end

    assign fu_ready_o = grant_p0;

    // ---- stage p1: registered writeback ports and pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1    <= '0;
            rr_ptr_p1 <= '0;
            for (int j = 0; j < NR_WB; j++) res_p1[j] <= '0;
        end else if (flush_i) begin
            vld_p1    <= '0;
            rr_ptr_p1 <= '0;
        end else begin
            vld_p1 <= port_vld_p0;
            if (any_grant_p0) rr_ptr_p1 <= ptr_nxt_p0;
            for (int j = 0; j < NR_WB; j++) begin
                if (port_vld_p0[j]) res_p1[j] <= fu_res_p0[sel_p0[j]];
            end
        end
    end

    for (genvar j = 0; j < NR_WB; j++) begin : g_pack
        assign wb_result_o[j*RES_W +: RES_W] = res_p1[j];
    end

    assign wb_valid_o = vld_p1;
    assign rr_ptr_o   = rr_ptr_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter with NR_FU=4, NR_WB=2.
module tb_wb_arbiter;

    localparam int NR_FU = 4;
    localparam int NR_WB = 2;
    localparam int RES_W = 3 + 5 + 32 + 4 + 1;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic [NR_FU-1:0]       fu_valid_i;
    logic [NR_FU*RES_W-1:0] fu_result_i;
    logic [NR_FU-1:0]       fu_ready_o;
    logic [NR_WB-1:0]       wb_valid_o;
    logic [NR_WB*RES_W-1:0] wb_result_o;
    logic [1:0]             rr_ptr_o;

    int tests = 0;
    int fails = 0;
    int seq   = 0;
    logic [RES_W-1:0] cur [NR_FU];
    logic [RES_W-1:0] exp_q [$];

    wb_arbiter #(.NR_FU(NR_FU), .NR_WB(NR_WB)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .fu_valid_i  (fu_valid_i),
        .fu_result_i (fu_result_i),
        .fu_ready_o  (fu_ready_o),
        .wb_valid_o  (wb_valid_o),
        .wb_result_o (wb_result_o),
        .rr_ptr_o    (rr_ptr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] mk(input logic [2:0] idx, input logic [4:0] rd,
                                            input logic [31:0] res, input logic ex);
        return {idx, rd, res, (ex ? 4'h2 : 4'h0), ex};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        fu_valid_i = v;
        for (int i = 0; i < NR_FU; i++) fu_result_i[i*RES_W +: RES_W] = cur[i];
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic cyc(input string nm, input logic [3:0] v, input logic [3:0] er,
                       input int p0, input int p1, input logic [1:0] eptr);
        drive(v);
        @(negedge clk);
        chk({nm, "_ready"}, 64'(fu_ready_o), 64'(er));
        if (p0 >= 0) exp_q.push_back(cur[p0]);
        if (p1 >= 0) exp_q.push_back(cur[p1]);
        @(posedge clk);
        #1;
        chk({nm, "_ptr"}, 64'(rr_ptr_o), 64'(eptr));
        for (int i = 0; i < NR_FU; i++) begin
            if (er[i]) begin
                cur[i] = mk(3'(i), 5'(i + 1), 32'hA000 + 32'(seq), 1'b0);
                seq++;
            end
        end
    endtask

    // Monitor: every presented writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [RES_W-1:0] got;
        logic [RES_W-1:0] e;
        if (!rst_i) begin
            for (int j = 0; j < NR_WB; j++) begin
                if (wb_valid_o[j]) begin
                    got = wb_result_o[j*RES_W +: RES_W];
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL wb_port%0d: got %0h, required no output", j, got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            fails++;
                            $display("FAIL wb_port%0d: got %0h, required %0h", j, got, e);
                        end
                    end
                end
            end
        end
    end

    // Fairness/round-robin table: valid, expected ready, port0 FU, port1 FU, pointer after.
    logic [3:0] t_v   [7] = '{4'b1111, 4'b1111, 4'b1011, 4'b0110, 4'b1010, 4'b1111, 4'b0010};
    logic [3:0] t_r   [7] = '{4'b0011, 4'b1100, 4'b0011, 4'b0110, 4'b1010, 4'b1100, 4'b0010};
    int         t_p0  [7] = '{0, 2, 0, 2, 3, 2, 1};
    int         t_p1  [7] = '{1, 3, 1, 1, 1, 3, -1};
    logic [1:0] t_ptr [7] = '{2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2};

    initial begin
        for (int i = 0; i < NR_FU; i++) cur[i] = mk(3'(i), 5'(i + 1), 32'h1000 + 32'(i), 1'b0);
        rst_i   = 1'b1;
        flush_i = 1'b0;
        drive(4'b1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(fu_ready_o), 64'h0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'h0);
        chk("rst_ptr", 64'(rr_ptr_o), 64'h0);
        chk("rst_wb_result", 64'(|wb_result_o), 64'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        for (int s = 0; s < 7; s++) begin
            cyc($sformatf("rr%0d", s), t_v[s], t_r[s], t_p0[s], t_p1[s], t_ptr[s]);
        end

        cur[3] = mk(3'd5, 5'd7, 32'hDEAD, 1'b0);
        cyc("solo_fu3", 4'b1000, 4'b1000, 3, -1, 2'd0);
        chk("solo_fu3_wb_valid", 64'(wb_valid_o), 64'h1);
        cyc("solo_fu0", 4'b0001, 4'b0001, 0, -1, 2'd1);

        drive(4'b1111);
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(fu_ready_o), 64'h0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        drive(4'b0000);
        chk("flush_wb_valid_t1", 64'(wb_valid_o), 64'h0);
        chk("flush_ptr_t1", 64'(rr_ptr_o), 64'h0);
        @(posedge clk);
        #1;
        chk("flush_wb_valid_t2", 64'(wb_valid_o), 64'h0);

        cur[3] = mk(3'd3, 5'd4, 32'hE0E0, 1'b1);
`ifdef WB_ARB_EX_PRIO_EN
        cyc("ex_prio", 4'b1111, 4'b1001, 3, 0, 2'd0);
`else
        cyc("ex_prio", 4'b1111, 4'b0011, 0, 1, 2'd2);
`endif

        // Grants of this cycle are lost to the asynchronous reset below.
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_wb_valid", 64'(wb_valid_o), 64'h3);
        rst_i = 1'b1;
        #1;
        chk("async_rst_wb_valid", 64'(wb_valid_o), 64'h0);
        chk("async_rst_wb_result", 64'(|wb_result_o), 64'h0);
        chk("async_rst_ready", 64'(fu_ready_o), 64'h0);
        chk("async_rst_ptr", 64'(rr_ptr_o), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        drive(4'b0000);
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
